rotary_offset_decoder: RTL and testbench

Quadrature decoder for the front-panel rotary encoder that produces the 8-bit `counter_offset` consumed by the LED-chaser clock divider, where `slow_clock = count[counter_offset]`. It synchronises and debounces the two raw encoder channels and decodes full detent-to-detent steps. Each step moves a saturating offset register within an 8-value window, so the chaser spans 8 speed settings from slowest to fastest. It is the producer end of the `counter_offset` interface.

---
 rtl/rotary_offset_decoder_if.sv | 28 ++
 rtl/rotary_offset_decoder.sv | 129 ++++++++++++
 tb/tb_rotary_offset_decoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rotary_offset_decoder_if.sv
// Encoder inputs and counter_offset outputs of the rotary offset decoder.
// The decoder is the master (producer); the consumer/driver side is the slave.
interface rotary_offset_decoder_if;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] counter_offset;
  logic       step_cw;
  logic       step_ccw;
  logic       quad_error;

  modport master (
    input  enc_a,
    input  enc_b,
    output counter_offset,
    output step_cw,
    output step_ccw,
    output quad_error
  );

  modport slave (
    output enc_a,
    output enc_b,
    input  counter_offset,
    input  step_cw,
    input  step_ccw,
    input  quad_error
  );
endinterface

// File: rtl/rotary_offset_decoder.sv
// Quadrature decoder turning debounced encoder detents into a saturating
// divider tap (counter_offset) for the LED-chaser clock divider.
module rotary_offset_decoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int OFFSET_MIN      = 18,
  parameter int OFFSET_MAX      = 25,
  parameter int OFFSET_RESET    = 25
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  rotary_offset_decoder_if.master bus
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [7:0]      OFF_MIN = 8'(OFFSET_MIN);
  localparam logic [7:0]      OFF_MAX = 8'(OFFSET_MAX);
  localparam logic [7:0]      OFF_RST = 8'(OFFSET_RESET);

  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {bus.enc_a, bus.enc_b};

  // Per-channel 2-FF synchroniser followed by a stability counter.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [1:0]       sync_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             filt_reg;

      always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
          sync_reg <= 2'b11;
          cnt_reg  <= '0;
          filt_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[0], raw[gi]};
          if (sync_reg[1] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            filt_reg <= sync_reg[1];
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  function automatic logic [1:0] cw_succ(input logic [1:0] p);
    case (p)
      2'b11:   cw_succ = 2'b01;
      2'b01:   cw_succ = 2'b00;
      2'b00:   cw_succ = 2'b10;
      default: cw_succ = 2'b11;
    endcase
  endfunction

  // Sub-count is 4 bits wide so that the +4 detent value is representable;
  // it is clamped to -4..+4 in case illegal jumps push it further.
  logic [1:0]        phase_prev_reg;
  logic signed [3:0] sub_reg, sub_next, sub_step;
  logic [7:0]        offset_reg, offset_next;
  logic              step_cw_reg, step_cw_next;
  logic              step_ccw_reg, step_ccw_next;
  logic              quad_error_reg, quad_error_next;

  always_comb begin
    sub_step        = sub_reg;
    sub_next        = sub_reg;
    offset_next     = offset_reg;
    step_cw_next    = 1'b0;
    step_ccw_next   = 1'b0;
    quad_error_next = 1'b0;

    if ((filt ^ phase_prev_reg) == 2'b11) begin
      quad_error_next = 1'b1;
    end else if (filt != phase_prev_reg) begin
      if (filt == cw_succ(phase_prev_reg)) begin
        sub_step = (sub_reg == 4'sd4) ? sub_reg : sub_reg + 4'sd1;
      end else begin
        sub_step = (sub_reg == -4'sd4) ? sub_reg : sub_reg - 4'sd1;
      end
    end
    sub_next = sub_step;

    if (filt == 2'b11 && phase_prev_reg != 2'b11) begin
      sub_next = 4'sd0;
      if (!quad_error_next) begin
        step_cw_next  = (sub_step == 4'sd4);
        step_ccw_next = (sub_step == -4'sd4);
      end
    end

    if (step_cw_next && offset_reg > OFF_MIN) begin
      offset_next = offset_reg - 8'd1;
    end else if (step_ccw_next && offset_reg < OFF_MAX) begin
      offset_next = offset_reg + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      phase_prev_reg <= 2'b11;
      sub_reg        <= 4'sd0;
      offset_reg     <= OFF_RST;
      step_cw_reg    <= 1'b0;
      step_ccw_reg   <= 1'b0;
      quad_error_reg <= 1'b0;
    end else begin
      phase_prev_reg <= filt;
      sub_reg        <= sub_next;
      offset_reg     <= offset_next;
      step_cw_reg    <= step_cw_next;
      step_ccw_reg   <= step_ccw_next;
      quad_error_reg <= quad_error_next;
    end
  end

  assign bus.counter_offset = offset_reg;
  assign bus.step_cw        = step_cw_reg;
  assign bus.step_ccw       = step_ccw_reg;
  assign bus.quad_error     = quad_error_reg;

endmodule

// File: tb/tb_rotary_offset_decoder.sv
// Directed bench for rotary_offset_decoder with a short debounce window.
module tb_rotary_offset_decoder;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   n_cw;
  int   n_ccw;
  int   n_err;

  rotary_offset_decoder_if bus ();

  rotary_offset_decoder #(
    .DEBOUNCE_CYCLES(4),
    .OFFSET_MIN     (18),
    .OFFSET_MAX     (25),
    .OFFSET_RESET   (25)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are one cycle wide, so one sample per negedge counts each once.
  initial begin
    n_cw  = 0;
    n_ccw = 0;
    n_err = 0;
  end
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.step_cw)    n_cw  = n_cw + 1;
      if (bus.step_ccw)   n_ccw = n_ccw + 1;
      if (bus.quad_error) n_err = n_err + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  task automatic set_phase(input logic a, input logic b, input int hold);
    bus.enc_a = a;
    bus.enc_b = b;
    repeat (hold) @(negedge clk);
  endtask

  task automatic cw_detent();
    set_phase(1'b0, 1'b1, 10);
    set_phase(1'b0, 1'b0, 10);
    set_phase(1'b1, 1'b0, 10);
    set_phase(1'b1, 1'b1, 10);
  endtask

  task automatic ccw_detent();
    set_phase(1'b1, 1'b0, 10);
    set_phase(1'b0, 1'b0, 10);
    set_phase(1'b0, 1'b1, 10);
    set_phase(1'b1, 1'b1, 10);
  endtask

  task automatic do_reset();
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_counts(input string name, input int d_cw, input int d_ccw,
                              input int d_err, input int cw0, input int ccw0, input int err0,
                              input logic [7:0] exp_off);
    checks++;
    if ((n_cw - cw0) !== d_cw) begin
      errors++;
      $display("FAIL %s step_cw count: got %0d required %0d", name, n_cw - cw0, d_cw);
    end
    checks++;
    if ((n_ccw - ccw0) !== d_ccw) begin
      errors++;
      $display("FAIL %s step_ccw count: got %0d required %0d", name, n_ccw - ccw0, d_ccw);
    end
    checks++;
    if ((n_err - err0) !== d_err) begin
      errors++;
      $display("FAIL %s quad_error count: got %0d required %0d", name, n_err - err0, d_err);
    end
    checks++;
    if (bus.counter_offset !== exp_off) begin
      errors++;
      $display("FAIL %s counter_offset: got %0d required %0d", name, bus.counter_offset, exp_off);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.counter_offset !== 8'd25 || bus.step_cw !== 1'b0 ||
          bus.step_ccw !== 1'b0 || bus.quad_error !== 1'b0) begin
        errors++;
        $display("FAIL reset cycle %0d: off=%0d cw=%b ccw=%b err=%b required off=25 pulses 0",
                 i, bus.counter_offset, bus.step_cw, bus.step_ccw, bus.quad_error);
      end
      @(negedge clk);
    end
    $display("test_reset: offset=%0d", bus.counter_offset);
  endtask

  task automatic test_single_cw();
    int cw0, ccw0, err0;
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    set_phase(1'b0, 1'b1, 10);
    set_phase(1'b0, 1'b0, 10);
    set_phase(1'b1, 1'b0, 10);
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (bus.counter_offset !== 8'd25 || bus.step_cw !== 1'b0) begin
      errors++;
      $display("FAIL single_cw edge6: off=%0d cw=%b required off=25 cw=0",
               bus.counter_offset, bus.step_cw);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.counter_offset !== 8'd24 || bus.step_cw !== 1'b1) begin
      errors++;
      $display("FAIL single_cw edge7: off=%0d cw=%b required off=24 cw=1",
               bus.counter_offset, bus.step_cw);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.step_cw !== 1'b0) begin
      errors++;
      $display("FAIL single_cw edge8 pulse width: cw=%b required 0", bus.step_cw);
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    check_counts("single_cw", 1, 0, 0, cw0, ccw0, err0, 8'd24);
    $display("test_single_cw: offset=%0d", bus.counter_offset);
  endtask

  task automatic test_saturation();
    int cw0, ccw0, err0;
    logic [7:0] exp_off;
    do_reset();
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    for (int i = 1; i <= 8; i++) begin
      cw_detent();
      exp_off = (25 - i < 18) ? 8'd18 : 8'(25 - i);
      checks++;
      if (bus.counter_offset !== exp_off) begin
        errors++;
        $display("FAIL saturation detent %0d: off=%0d required %0d", i, bus.counter_offset, exp_off);
      end
      $display("cw detent %0d: offset=%0d", i, bus.counter_offset);
    end
    check_counts("sat_min", 8, 0, 0, cw0, ccw0, err0, 8'd18);
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    ccw_detent();
    check_counts("sat_ccw", 0, 1, 0, cw0, ccw0, err0, 8'd19);
    $display("test_saturation: offset=%0d", bus.counter_offset);
  endtask

  task automatic test_bounce();
    int cw0, ccw0, err0;
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    for (int i = 0; i < 5; i++) begin
      set_phase(1'b0, 1'b1, 3);
      set_phase(1'b1, 1'b1, 5);
    end
    repeat (10) @(negedge clk);
    check_counts("bounce", 0, 0, 0, cw0, ccw0, err0, 8'd19);
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    cw_detent();
    check_counts("bounce_follow_cw", 1, 0, 0, cw0, ccw0, err0, 8'd18);
    $display("test_bounce: offset=%0d", bus.counter_offset);
  endtask

  task automatic test_partial_illegal();
    int cw0, ccw0, err0;
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    set_phase(1'b0, 1'b1, 10);
    set_phase(1'b1, 1'b1, 10);
    check_counts("partial", 0, 0, 0, cw0, ccw0, err0, 8'd18);
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    set_phase(1'b0, 1'b0, 10);
    check_counts("illegal_jump", 0, 0, 1, cw0, ccw0, err0, 8'd18);
    set_phase(1'b1, 1'b0, 10);
    set_phase(1'b1, 1'b1, 10);
    check_counts("illegal_return", 0, 0, 1, cw0, ccw0, err0, 8'd18);
    $display("test_partial_illegal: offset=%0d", bus.counter_offset);
  endtask

  task automatic test_reset_mid_turn();
    int cw0, ccw0, err0;
    set_phase(1'b0, 1'b1, 10);
    set_phase(1'b0, 1'b0, 10);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.counter_offset !== 8'd25) begin
      errors++;
      $display("FAIL reset_mid_turn offset: got %0d required 25", bus.counter_offset);
    end
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    @(negedge clk);
    repeat (9) @(negedge clk);
    set_phase(1'b1, 1'b0, 10);
    set_phase(1'b1, 1'b1, 10);
    // Both channels mature together after reset (11 -> 00), a single illegal jump.
    check_counts("reset_mid_turn", 0, 0, 1, cw0, ccw0, err0, 8'd25);
    cw0 = n_cw; ccw0 = n_ccw; err0 = n_err;
    ccw_detent();
    check_counts("sat_max_ccw", 0, 1, 0, cw0, ccw0, err0, 8'd25);
    $display("test_reset_mid_turn: offset=%0d", bus.counter_offset);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    test_reset();
    test_single_cw();
    test_saturation();
    test_bounce();
    test_partial_illegal();
    test_reset_mid_turn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
